// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the dual-port double-buffer RF sequencing controller.
package rf_ctrl_pkg;

  typedef enum logic [2:0] {
    RF_ST_IDLE  = 3'd0,
    RF_ST_PRIME = 3'd1,
    RF_ST_RUN   = 3'd2,
    RF_ST_SWAP  = 3'd3,
    RF_ST_DRAIN = 3'd4
  } rf_state_e;

endpackage

// File: rtl/rf_ctrl_addr_cnt.sv
// Wrapping bank address counter with pass counting; flags the final address of the final pass.
module rf_ctrl_addr_cnt #(
  parameter int unsigned ADDR_BITWIDTH  = 2,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned REUSE_BITWIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      advance,
  input  logic [REUSE_BITWIDTH-1:0] passes,
  output logic [ADDR_BITWIDTH-1:0]  addr,
  output logic                      last,
  output logic                      finished
);

  logic [ADDR_BITWIDTH-1:0]  addr_q;
  logic [REUSE_BITWIDTH-1:0] pass_q;
  logic [REUSE_BITWIDTH-1:0] pass_max;
  logic                      fin_q;
  logic                      wrap;

  // A pass count of zero means a single pass.
  always_comb begin
    pass_max = (passes == '0) ? REUSE_BITWIDTH'(1) : passes;
    wrap     = (addr_q == ADDR_BITWIDTH'(DEPTH - 1));
    last     = advance && !fin_q && wrap && (pass_q == (pass_max - REUSE_BITWIDTH'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      addr_q <= '0;
      pass_q <= '0;
      fin_q  <= 1'b0;
    end else if (advance && !fin_q) begin
      if (wrap) begin
        addr_q <= '0;
        pass_q <= pass_q + 1'b1;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
      if (last) begin
        fin_q <= 1'b1;
      end
    end
  end

  assign addr     = addr_q;
  assign finished = fin_q;

endmodule

// File: rtl/rf_iw_dpdb_ctrl.sv
// Double-buffer RF sequencer: fills one bank from the GB stream while the other feeds the MAC.
// Optional stall counter output enabled by defining RF_DPDB_CTRL_PERF_EN.
module rf_iw_dpdb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = 16,
  parameter int unsigned ADDR_BITWIDTH  = 2,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned REUSE_BITWIDTH = 4,
  parameter int unsigned TILE_BITWIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [TILE_BITWIDTH-1:0]  num_tiles,
  input  logic [REUSE_BITWIDTH-1:0] reuse,
  input  logic                      gb_valid,
  input  logic [DATA_BITWIDTH-1:0]  gb_data,
  output logic                      gb_ready,
  output logic                      rf_write_sel,
  output logic                      rf_write_en,
  output logic [ADDR_BITWIDTH-1:0]  rf_w_addr,
  output logic [DATA_BITWIDTH-1:0]  rf_w_data,
  output logic [ADDR_BITWIDTH-1:0]  rf_r_addr,
  output logic                      mac_valid,
  output logic                      mac_last,
  output logic                      busy,
  output logic                      done
`ifdef RF_DPDB_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles
`endif
);

  rf_state_e                 state_q, state_d;
  logic [TILE_BITWIDTH-1:0]  num_tiles_q;
  logic [REUSE_BITWIDTH-1:0] reuse_q;
  logic [TILE_BITWIDTH-1:0]  swap_cnt_q;
  logic                      write_sel_q;
  logic                      mac_valid_q, mac_last_q, done_q, done_d;
  logic                      start_acc, cnt_clear, read_issue, more_tiles;
  logic                      fill_last, fill_fin, drain_last, drain_fin;

  assign start_acc = (state_q == RF_ST_IDLE) && start;
  assign cnt_clear = start_acc || (state_q == RF_ST_SWAP);
  // Swaps so far equal tiles already handed to the read side; one more is loaded in the fill bank.
  assign more_tiles = ({1'b0, swap_cnt_q} + (TILE_BITWIDTH + 1)'(1)) < {1'b0, num_tiles_q};

  rf_ctrl_addr_cnt #(
    .ADDR_BITWIDTH (ADDR_BITWIDTH),
    .DEPTH         (DEPTH),
    .REUSE_BITWIDTH(REUSE_BITWIDTH)
  ) u_fill_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (rf_write_en),
    .passes  (REUSE_BITWIDTH'(1)),
    .addr    (rf_w_addr),
    .last    (fill_last),
    .finished(fill_fin)
  );

  rf_ctrl_addr_cnt #(
    .ADDR_BITWIDTH (ADDR_BITWIDTH),
    .DEPTH         (DEPTH),
    .REUSE_BITWIDTH(REUSE_BITWIDTH)
  ) u_drain_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (read_issue),
    .passes  (reuse_q),
    .addr    (rf_r_addr),
    .last    (drain_last),
    .finished(drain_fin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      RF_ST_IDLE: begin
        if (start) begin
          if (num_tiles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RF_ST_PRIME;
          end
        end
      end
      RF_ST_PRIME: if (fill_last) state_d = RF_ST_SWAP;
      RF_ST_SWAP:  state_d = more_tiles ? RF_ST_RUN : RF_ST_DRAIN;
      RF_ST_RUN: begin
        if ((fill_fin || fill_last) && (drain_fin || drain_last)) begin
          state_d = RF_ST_SWAP;
        end
      end
      // drain_fin rises in the cycle the final read's data is on the MAC port.
      RF_ST_DRAIN: begin
        if (drain_fin) begin
          state_d = RF_ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RF_ST_IDLE;
    endcase
  end

  always_comb begin
    gb_ready   = 1'b0;
    read_issue = 1'b0;
    unique case (state_q)
      RF_ST_PRIME: gb_ready = 1'b1;
      RF_ST_RUN: begin
        gb_ready   = !fill_fin;
        read_issue = !drain_fin;
      end
      RF_ST_DRAIN: read_issue = !drain_fin;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_tiles_q <= '0;
      reuse_q     <= '0;
      swap_cnt_q  <= '0;
      write_sel_q <= 1'b1;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (start_acc) begin
        num_tiles_q <= num_tiles;
        reuse_q     <= reuse;
        swap_cnt_q  <= '0;
        write_sel_q <= 1'b1;
      end else if (state_q == RF_ST_SWAP) begin
        swap_cnt_q  <= swap_cnt_q + 1'b1;
        write_sel_q <= ~write_sel_q;
      end
      mac_valid_q <= read_issue;
      mac_last_q  <= drain_last;
      done_q      <= done_d;
    end
  end

  assign rf_write_en  = gb_valid & gb_ready;
  assign rf_w_data    = gb_ready ? gb_data : '0;
  assign rf_write_sel = write_sel_q;
  assign mac_valid    = mac_valid_q;
  assign mac_last     = mac_last_q;
  assign busy         = (state_q != RF_ST_IDLE);
  assign done         = done_q;

`ifdef RF_DPDB_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      perf_q <= '0;
    end else if ((state_q == RF_ST_RUN) && drain_fin && !fill_fin && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_q;
`endif

endmodule
